// File: rtl/idex_if.sv
// ID/EX pipeline register bus: decode-side fields in, execute-side fields out,
// plus the stall/bubble/flush controls and the bubble counter.
interface idex_if #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 4
);
   logic                stall, bubble, flush;
   logic                validID;
   logic [DATA_W-1:0]   pc4ID, rsdataID, rtdataID, immID;
   logic [REG_AW-1:0]   rsID, rtID, rdID;
   logic                RegWriteID, MemReadID, MemWriteID, MemtoRegID, ALUSrcID, RegDstID, BranchID;
   logic [ALUOP_W-1:0]  ALUOpID;

   logic                validEX;
   logic [DATA_W-1:0]   pc4EX, rsdataEX, rtdataEX, immEX;
   logic [REG_AW-1:0]   rsEX, rtEX, rdEX, writeregEX;
   logic                RegWriteEX, MemReadEX, MemWriteEX, MemtoRegEX, ALUSrcEX, RegDstEX, BranchEX;
   logic [ALUOP_W-1:0]  ALUOpEX;
   logic [15:0]         bubblecnt;

   modport master (
      output stall, bubble, flush, validID, pc4ID, rsdataID, rtdataID, immID,
             rsID, rtID, rdID, RegWriteID, MemReadID, MemWriteID, MemtoRegID,
             ALUSrcID, RegDstID, BranchID, ALUOpID,
      input  validEX, pc4EX, rsdataEX, rtdataEX, immEX, rsEX, rtEX, rdEX, writeregEX,
             RegWriteEX, MemReadEX, MemWriteEX, MemtoRegEX, ALUSrcEX, RegDstEX,
             BranchEX, ALUOpEX, bubblecnt
   );

   modport slave (
      input  stall, bubble, flush, validID, pc4ID, rsdataID, rtdataID, immID,
             rsID, rtID, rdID, RegWriteID, MemReadID, MemWriteID, MemtoRegID,
             ALUSrcID, RegDstID, BranchID, ALUOpID,
      output validEX, pc4EX, rsdataEX, rtdataEX, immEX, rsEX, rtEX, rdEX, writeregEX,
             RegWriteEX, MemReadEX, MemWriteEX, MemtoRegEX, ALUSrcEX, RegDstEX,
             BranchEX, ALUOpEX, bubblecnt
   );
endinterface

// File: rtl/idex_reg.sv
// ID/EX pipeline register: stall holds, bubble/flush load a NOP, else capture ID.
// Optional IDEX_BUBBLECNT_EN adds a saturating 16-bit load-use bubble counter.
module idex_reg #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   idex_if.slave  io
);
   typedef struct packed {
      logic                valid;
      logic [DATA_W-1:0]   pc4, rsdata, rtdata, imm;
      logic [REG_AW-1:0]   rs, rt, rd;
      logic                regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch;
      logic [ALUOP_W-1:0]  aluop;
   } ex_t;

   ex_t q, nxt;
   logic nop;

   assign nop = io.bubble | io.flush;

   // Data/index fields always load so a NOP never carries X downstream.
   always_comb begin
      nxt          = '0;
      nxt.pc4      = io.pc4ID;
      nxt.rsdata   = io.rsdataID;
      nxt.rtdata   = io.rtdataID;
      nxt.imm      = io.immID;
      nxt.rs       = io.rsID;
      nxt.rt       = io.rtID;
      nxt.rd       = io.rdID;
      if (!nop) begin
         nxt.valid    = io.validID;
         nxt.regwrite = io.RegWriteID;
         nxt.memread  = io.MemReadID;
         nxt.memwrite = io.MemWriteID;
         nxt.memtoreg = io.MemtoRegID;
         nxt.alusrc   = io.ALUSrcID;
         nxt.regdst   = io.RegDstID;
         nxt.branch   = io.BranchID;
         nxt.aluop    = io.ALUOpID;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         q <= '0;
      else if (!io.stall) q <= nxt;
   end

   assign io.validEX    = q.valid;
   assign io.pc4EX      = q.pc4;
   assign io.rsdataEX   = q.rsdata;
   assign io.rtdataEX   = q.rtdata;
   assign io.immEX      = q.imm;
   assign io.rsEX       = q.rs;
   assign io.rtEX       = q.rt;
   assign io.rdEX       = q.rd;
   assign io.RegWriteEX = q.regwrite;
   assign io.MemReadEX  = q.memread;
   assign io.MemWriteEX = q.memwrite;
   assign io.MemtoRegEX = q.memtoreg;
   assign io.ALUSrcEX   = q.alusrc;
   assign io.RegDstEX   = q.regdst;
   assign io.BranchEX   = q.branch;
   assign io.ALUOpEX    = q.aluop;
   // Hazard unit compares this against ID rs/rt in the same cycle.
   assign io.writeregEX = q.regdst ? q.rd : q.rt;

`ifdef IDEX_BUBBLECNT_EN
   logic [15:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      cnt <= '0;
      else if (!io.stall && io.bubble && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
   end
   assign io.bubblecnt = cnt;
`else
   assign io.bubblecnt = 16'h0000;
`endif
endmodule

// File: tb/tb_idex_reg.sv
// Directed + randomized bench for idex_reg against a field-level reference model.
module tb_idex_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   idex_if #(.DATA_W(32), .REG_AW(5), .ALUOP_W(4)) io ();
   idex_reg #(.DATA_W(32), .REG_AW(5), .ALUOP_W(4)) dut (.clk(clk), .rst_n(rst_n), .io(io));

   always #5 clk = ~clk;

   // reference state: what EX should hold
   logic        e_valid;
   logic [31:0] e_pc4, e_rsd, e_rtd, e_imm;
   logic [4:0]  e_rs, e_rt, e_rd;
   logic [6:0]  e_ctl;   // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,Branch}
   logic [3:0]  e_aluop;
   int          e_cnt;

   task automatic model_reset();
      e_valid = 0; e_pc4 = 0; e_rsd = 0; e_rtd = 0; e_imm = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_ctl = 0; e_aluop = 0; e_cnt = 0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [4:0] wr;
      int cnt_exp;
      wr = e_ctl[1] ? e_rd : e_rt;
`ifdef IDEX_BUBBLECNT_EN
      cnt_exp = e_cnt;
`else
      cnt_exp = 0;
`endif
      chk({tag, ".validEX"},  io.validEX,  e_valid);
      chk({tag, ".pc4EX"},    io.pc4EX,    e_pc4);
      chk({tag, ".rsdataEX"}, io.rsdataEX, e_rsd);
      chk({tag, ".rtdataEX"}, io.rtdataEX, e_rtd);
      chk({tag, ".immEX"},    io.immEX,    e_imm);
      chk({tag, ".idx"},      {io.rsEX, io.rtEX, io.rdEX}, {e_rs, e_rt, e_rd});
      chk({tag, ".ctl"},      {io.RegWriteEX, io.MemReadEX, io.MemWriteEX, io.MemtoRegEX,
                               io.ALUSrcEX, io.RegDstEX, io.BranchEX}, e_ctl);
      chk({tag, ".ALUOpEX"},  io.ALUOpEX,  e_aluop);
      chk({tag, ".writeregEX"}, io.writeregEX, wr);
      chk({tag, ".bubblecnt"}, io.bubblecnt, cnt_exp[15:0]);
   endtask

   task automatic set_id_rand();
      io.validID = 1'($urandom);
      io.pc4ID = $urandom; io.rsdataID = $urandom; io.rtdataID = $urandom; io.immID = $urandom;
      io.rsID = 5'($urandom); io.rtID = 5'($urandom); io.rdID = 5'($urandom);
      {io.RegWriteID, io.MemReadID, io.MemWriteID, io.MemtoRegID,
       io.ALUSrcID, io.RegDstID, io.BranchID} = 7'($urandom);
      io.ALUOpID = 4'($urandom);
   endtask

   task automatic set_id_zero();
      io.validID = 1; io.pc4ID = 0; io.rsdataID = 0; io.rtdataID = 0; io.immID = 0;
      io.rsID = 0; io.rtID = 0; io.rdID = 0;
      {io.RegWriteID, io.MemReadID, io.MemWriteID, io.MemtoRegID,
       io.ALUSrcID, io.RegDstID, io.BranchID} = 0;
      io.ALUOpID = 0;
   endtask

   // one rising edge, model follows the ID/EX rules, check 1 time unit later
   task automatic step(input string tag);
      @(posedge clk);
      if (rst_n && !io.stall) begin
         e_pc4 = io.pc4ID; e_rsd = io.rsdataID; e_rtd = io.rtdataID; e_imm = io.immID;
         e_rs = io.rsID; e_rt = io.rtID; e_rd = io.rdID;
         if (io.bubble || io.flush) begin
            e_valid = 0; e_ctl = 0; e_aluop = 0;
         end else begin
            e_valid = io.validID;
            e_ctl = {io.RegWriteID, io.MemReadID, io.MemWriteID, io.MemtoRegID,
                     io.ALUSrcID, io.RegDstID, io.BranchID};
            e_aluop = io.ALUOpID;
         end
         if (io.bubble && e_cnt < 65535) e_cnt++;
      end
      #1;
      chk_all(tag);
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      io.stall = 0; io.bubble = 0; io.flush = 0;
      // reset with every ID input at all-ones
      io.validID = 1; io.pc4ID = '1; io.rsdataID = '1; io.rtdataID = '1; io.immID = '1;
      io.rsID = '1; io.rtID = '1; io.rdID = '1;
      {io.RegWriteID, io.MemReadID, io.MemWriteID, io.MemtoRegID,
       io.ALUSrcID, io.RegDstID, io.BranchID} = '1;
      io.ALUOpID = '1;
      step("reset0");
      step("reset1");
      rst_n = 1;

      set_id_zero(); io.RegWriteID = 1; io.rdID = 9; io.RegDstID = 1; io.rtID = 3;
      step("post_reset");

      set_id_zero(); io.MemReadID = 1; io.rtID = 8; io.rdID = 2; io.immID = 32'h10; io.ALUSrcID = 1;
      step("lw");

      set_id_zero(); io.RegWriteID = 1; io.ALUOpID = 4'h2; io.RegDstID = 1; io.rdID = 4;
      io.bubble = 1;
      step("bubble");
      io.bubble = 0;
      step("after_bubble");

      set_id_zero(); io.MemWriteID = 1; io.rtdataID = 32'hDEADBEEF; io.rtID = 7;
      step("load_sw");
      io.stall = 1; io.flush = 1;
      for (int i = 0; i < 3; i++) begin
         set_id_rand();
         step("stall_hold");
      end
      io.stall = 0; io.flush = 0;
      set_id_rand();
      step("stall_release");

      set_id_rand(); io.flush = 1; io.bubble = 1;
      step("flush_bubble");
      io.flush = 0; io.bubble = 0;
      set_id_rand(); io.flush = 1;
      step("flush_only");
      io.flush = 0;

      for (int i = 0; i < 200; i++) begin
         set_id_rand();
         io.stall  = ($urandom_range(0, 3) == 0);
         io.bubble = ($urandom_range(0, 3) == 0);
         io.flush  = ($urandom_range(0, 4) == 0);
         step("random");
      end

      // asynchronous reset in the middle of a stall
      io.stall = 1; io.bubble = 1;
      set_id_rand();
      #2 rst_n = 0;
      model_reset();
      #1 chk_all("async_reset");
      @(negedge clk);
      rst_n = 1;
      step("reset_stall_hold");
      io.stall = 0; io.bubble = 0;
      set_id_rand();
      step("reset_resume");

`ifdef IDEX_BUBBLECNT_EN
      io.bubble = 1;
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk);
         if (e_cnt < 65535) e_cnt++;
      end
      #1 chk("sat_bubblecnt", io.bubblecnt, 16'hFFFF);
      @(negedge clk);
      step("sat_hold");
      io.bubble = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/idex_reg.md
Name: idex_reg

Overview:
- ID/EX pipeline register of the 5-stage pipelined CPU. It sits between the decode stage and the execute stage.
- Captures the decoded control and data fields every cycle.
- Inserts a bubble when the load-use hazard unit requests one, or when a taken branch flushes the stage. Freezes on a global pipeline stall.
- Feeds MemReadEX and writeregEX back to the load-use hazard unit.

Parameters:
- DATA_W, 32, width of PC, register-operand and immediate fields
- REG_AW, 5, register-index width
- ALUOP_W, 4, ALU operation code width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  global freeze (memory wait); holds all contents
- bubble  in  1  load-use hazard request (IDEXhold from the hazard unit); loads a NOP into EX
- flush  in  1  taken branch/jump resolved; loads a NOP into EX
- validID  in  1  ID stage holds a real instruction
- pc4ID  in  DATA_W  PC+4 of the ID instruction
- rsdataID  in  DATA_W  register file read port 1
- rtdataID  in  DATA_W  register file read port 2
- immID  in  DATA_W  sign-extended immediate
- rsID, rtID, rdID  in  REG_AW each  register indices
- RegWriteID, MemReadID, MemWriteID, MemtoRegID, ALUSrcID, RegDstID, BranchID  in  1 each  control bits
- ALUOpID  in  ALUOP_W  ALU operation
- validEX  out  1  EX holds a real instruction
- pc4EX, rsdataEX, rtdataEX, immEX  out  DATA_W  registered copies
- rsEX, rtEX, rdEX  out  REG_AW  registered copies
- RegWriteEX, MemReadEX, MemWriteEX, MemtoRegEX, ALUSrcEX, RegDstEX, BranchEX  out  1 each  registered control bits
- ALUOpEX  out  ALUOP_W  registered ALU operation
- writeregEX  out  REG_AW  destination register: RegDstEX ? rdEX : rtEX (combinational from registered state)
- bubblecnt  out  16  bubble counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs 0, validEX=0, bubblecnt=0. writeregEX is therefore 0.
- Release of reset is sampled on the next rising clk. No output changes until then.
- Update at each rising clk, priority highest first:
  1. stall=1: every register holds, including validEX. bubble/flush are ignored that cycle and not remembered.
  2. flush=1 or bubble=1: NOP load.
     - validEX=0.
     - All control outputs (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp) = 0.
     - Data and index fields (pc4, rsdata, rtdata, imm, rs, rt, rd) still load from the ID inputs. They are don't-care downstream but must not be X.
  3. Otherwise: all fields load from the ID inputs. validEX=validID.
- validID=0 with no stall/bubble/flush: fields load as-is. The control bits are expected to be 0 from decode; this block does not mask them.
- Latency: exactly one cycle, ID input to EX output.
- writeregEX and MemReadEX must reflect the registered state in the same cycle, with no extra latency. The hazard unit compares them against the ID rs/rt.
- flush and bubble asserted together produce a single NOP.
- Reset asserted mid-stall clears everything immediately. The stall has no effect after reset.
- No internal handshake. The caller holds the ID inputs stable while stall=1.

Optional Feature:
- Macro: IDEX_BUBBLECNT_EN.
- Defined:
  - bubblecnt increments by 1 on each rising clk where stall=0 and bubble=1, counting flush-only cycles not at all.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared only by reset.
- Not defined: bubblecnt is tied to 16'h0000 and no counter flops are synthesised.

Test Plan:
- Reset: hold rst_n=0 with all ID inputs at 1s, toggle clk → every output 0, writeregEX=0. Deassert rst_n, then one edge with RegWriteID=1, rdID=5'd9, RegDstID=1 → RegWriteEX=1, writeregEX=9.
- Normal flow: drive lw (MemReadID=1, rtID=8, RegDstID=0, immID=32'h10) → next cycle MemReadEX=1, writeregEX=8, immEX=32'h10, validEX=1.
- Load-use bubble: bubble=1 for one edge while add is in ID (RegWriteID=1, ALUOpID=4'h2) → validEX=0, RegWriteEX=0, ALUOpEX=0. Next edge with bubble=0 → RegWriteEX=1, ALUOpEX=2.
- Stall priority: stall=1 and flush=1 for 3 edges with EX holding MemWriteEX=1, rtdataEX=32'hDEADBEEF → outputs unchanged for all 3 cycles. Release stall with flush=0 → normal load.
- Flush and bubble together: flush=1 and bubble=1 on one edge → single NOP. With IDEX_BUBBLECNT_EN defined, bubblecnt +1.
- Counter saturation (IDEX_BUBBLECNT_EN defined): force or count 65535 bubbles, then 2 more → bubblecnt stays 16'hFFFF. Without the macro, bubblecnt=0 throughout.
